// File: rtl/div_seq_ctrl.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per CALC cycle.
// A divide by zero skips CALC and reports quotient=FFFF, remainder=dividend.
module div_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        div_zero,
   output logic        inv_flag,
   output logic [4:0]  iter
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] rq_q, rq_d;
   logic [15:0] div_q, div_d;
   logic [15:0] quot_q, quot_d;
   logic [15:0] rem_q, rem_d;
   logic        dz_q, dz_d;
   logic [4:0]  iter_q, iter_d;

   logic [31:0] rq_sh;
   logic [16:0] trial;
   logic        no_borrow;
   logic [31:0] rq_step;

   // The bit shifted out of R is a 17th remainder bit: if set, R >= D for sure.
   always_comb begin
      rq_sh     = {rq_q[30:0], 1'b0};
      trial     = {1'b0, rq_sh[31:16]} + {1'b0, ~div_q} + 17'd1;
      no_borrow = rq_q[31] | trial[16];
      rq_step   = no_borrow ? {trial[15:0], rq_sh[15:1], 1'b1} : rq_sh;
   end

   always_comb begin
      state_d = state_q;
      rq_d    = rq_q;
      div_d   = div_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      iter_d  = iter_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               div_d  = divisor;
               rq_d   = {16'h0000, dividend};
               iter_d = 5'd0;
               dz_d   = 1'b0;
               if (divisor == 16'h0000) begin
                  quot_d  = 16'hFFFF;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            rq_d   = rq_step;
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'd15) begin
               quot_d  = rq_step[15:0];
               rem_d   = rq_step[31:16];
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rq_q    <= 32'h0;
         div_q   <= 16'h0;
         quot_q  <= 16'h0;
         rem_q   <= 16'h0;
         dz_q    <= 1'b0;
         iter_q  <= 5'd0;
      end else begin
         state_q <= state_d;
         rq_q    <= rq_d;
         div_q   <= div_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         iter_q  <= iter_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign inv_flag  = (state_q == StCalc);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;
   assign iter      = iter_q;

endmodule
